spi_pkt_ingest: RTL and testbench
=================================

Name: spi_pkt_ingest

Overview:
- Packet ingest stage directly upstream of the data pipeline router.
- Accepts the byte stream from the SPI slave front end and packs it into 32-bit words, MSB first.
- Writes each packet's payload into a fixed SRAM/SDRAM buffer region through a single-word write handshake.
- Presents the filled region to the router with a pkt_avail/done handshake. Oversized or zero-length packets are detected and discarded.

Parameters:
- ADDR_W, 23, memory word-address width.
- BUF_BASE, 23'h300000, first word address of the packet buffer.
- BUF_WORDS, 1024, buffer capacity in 32-bit words; max legal payload length.

Ports:
- clk  in  1  system clock
- rst_l  in  1  asynchronous active-low reset
- rx_byte  in  8  received SPI byte
- rx_valid  in  1  rx_byte valid
- rx_ready  out  1  byte accepted when rx_valid&&rx_ready at posedge
- mem_ptr  out  ADDR_W  write word address
- mem_data  out  32  write data
- mem_w_en  out  1  write request; held until mem_done
- mem_done  in  1  write completed (level sampled at posedge)
- pkt_avail  out  1  packet region valid for router
- pkt_begin  out  ADDR_W  first payload word address (always BUF_BASE)
- pkt_end  out  ADDR_W  one past last payload word (BUF_BASE+L)
- dpr_done  in  1  router finished with packet (level)
- err_len  out  1  one-cycle pulse: illegal length header

Behaviour:
- Reset (async, rst_l low): state IDLE; rx_ready=0 for the reset cycle, then 1. mem_w_en=0, mem_ptr=BUF_BASE, mem_data=0, pkt_avail=0, pkt_begin=BUF_BASE, pkt_end=BUF_BASE, err_len=0. Byte index, word counter and length register are cleared. Reset mid-packet discards all partial state; the buffer contents are don't-care.
- Packing: bytes fill a 32-bit shift register with the first byte in [31:24]. A word completes on the 4th accepted byte; the 2-bit byte index wraps 3->0.
- Packet format: word 0 = payload length L (unsigned 32-bit), followed by L payload words. The header is never written to memory.
- States:
  - IDLE: rx_ready=1; collects header. When the header completes: if 1<=L<=BUF_WORDS, latch L, set word counter=0 and go to COLLECT. Otherwise pulse err_len next cycle, load drain count=L and go to DRAIN; L=0 returns to IDLE.
  - COLLECT: rx_ready=1. On the 4th byte of a word go to WRITE. The next cycle drives mem_w_en=1, mem_ptr=BUF_BASE+counter, mem_data=word.
  - WRITE: rx_ready=0; mem_w_en, mem_ptr and mem_data are held stable. On mem_done=1: mem_w_en=0 next cycle and counter increments. If counter+1==L go to AVAIL, else go to COLLECT.
  - AVAIL: pkt_avail=1, pkt_end=BUF_BASE+L, rx_ready=0. dpr_done=1 gives pkt_avail=0 next cycle and moves to RELEASE.
  - RELEASE: rx_ready=0; waits for dpr_done=0, then goes to IDLE. This guarantees the router sees pkt_avail low before any new packet.
  - DRAIN: rx_ready=1; accepts and discards 4*L bytes, then returns to IDLE. No memory writes; pkt_avail stays 0.
- Latency: the last payload byte accepted at cycle t gives mem_w_en=1 at t+1. With mem_done at t+k, pkt_avail=1 at t+k+1.
- mem_done is ignored outside WRITE. dpr_done is ignored outside AVAIL and RELEASE.
- mem_ptr arithmetic is ADDR_W bits; BUF_BASE+BUF_WORDS must not exceed 2^ADDR_W (elaboration check).
- rx_valid with rx_ready=0 means the byte is not consumed, so the upstream holds it.

Test Plan:
- Header 0x00000002, payload 0xDEADBEEF, 0x01234567, mem_done one cycle after each w_en. Required: two writes at 0x300000 and 0x300001 with those data, pkt_avail=1, pkt_begin=0x300000, pkt_end=0x300002.
- Same packet with mem_done delayed 5 cycles and rx_valid held high. Required: rx_ready=0 throughout WRITE, no byte lost, mem_ptr/mem_data stable until mem_done.
- Header 0x00000401 (1025) followed by 4100 bytes, then a valid 1-word packet. Required: err_len pulses once, no mem_w_en during the drain, the second packet gives pkt_end=0x300001.
- Header 0x00000000. Required: err_len pulse, next 4 bytes parsed as a new header.
- pkt_avail=1 and dpr_done held high for 3 cycles. Required: pkt_avail=0 one cycle after the first dpr_done, rx_ready=0 until dpr_done falls, then rx_ready=1.
- rst_l pulled low during the 3rd payload word write. Required: all outputs return to reset values immediately, and the next header is parsed cleanly.

Source files
------------

// File: rtl/spi_pkt_ingest_if.sv
// Purpose : bundles the byte-stream, memory-write and router handshakes of the packet ingest stage.
// Latency : n/a (signal bundle only).
// Backpressure: rx_ready stalls the byte source; mem_done completes a held write; dpr_done releases a packet.
// Ports (master = ingest block, slave = its environment):
//   rx_byte/rx_valid -> rx_ready            byte stream in, accepted on rx_valid && rx_ready
//   mem_ptr/mem_data/mem_w_en -> mem_done   single-word write, held until mem_done
//   pkt_avail/pkt_begin/pkt_end -> dpr_done packet region offered to the router
//   err_len                                 one-cycle pulse on an illegal length header
interface spi_pkt_ingest_if #(
  parameter int unsigned ADDR_W = 23
);
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_ptr;
  logic [31:0]       mem_data;
  logic              mem_w_en;
  logic              mem_done;
  logic              pkt_avail;
  logic [ADDR_W-1:0] pkt_begin;
  logic [ADDR_W-1:0] pkt_end;
  logic              dpr_done;
  logic              err_len;

  modport master (
    input  rx_byte, rx_valid, mem_done, dpr_done,
    output rx_ready, mem_ptr, mem_data, mem_w_en,
           pkt_avail, pkt_begin, pkt_end, err_len
  );

  modport slave (
    output rx_byte, rx_valid, mem_done, dpr_done,
    input  rx_ready, mem_ptr, mem_data, mem_w_en,
           pkt_avail, pkt_begin, pkt_end, err_len
  );
endinterface

// File: rtl/spi_pkt_ingest.sv
// Purpose : packs SPI bytes MSB-first into 32-bit words, writes a length-prefixed packet payload into a fixed buffer, offers it to the router.
// Latency : last byte of a word at cycle t -> mem_w_en at t+1; final mem_done at cycle u -> pkt_avail at u+1.
// Backpressure: rx_ready drops while a write is outstanding and while a packet is owned by the router; bad lengths are drained, not stalled.
// Ports:
//   clk, rst_l : system clock, asynchronous active-low reset
//   bus        : spi_pkt_ingest_if master modport (byte stream in, memory write out, router handshake out, err_len pulse)
// The interface instance must be built with the same ADDR_W as this module.
module spi_pkt_ingest #(
  parameter int unsigned       ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] BUF_BASE  = 23'h300000,
  parameter int unsigned       BUF_WORDS = 1024
) (
  input  logic                    clk,
  input  logic                    rst_l,
  spi_pkt_ingest_if.master        bus
);

  // Payload counter must hold values up to and including BUF_WORDS.
  localparam int CNT_W = $clog2(BUF_WORDS + 1);

  // The buffer region must fit entirely inside the word-address space.
  if ((64'(BUF_BASE) + 64'(BUF_WORDS)) > (64'd1 << ADDR_W)) begin : g_buf_range_chk
    $error("spi_pkt_ingest: BUF_BASE + BUF_WORDS exceeds the ADDR_W address space");
  end
  if (BUF_WORDS < 1) begin : g_buf_size_chk
    $error("spi_pkt_ingest: BUF_WORDS must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_AVAIL,
    S_RELEASE,
    S_DRAIN
  } state_t;

  state_t state_q, state_nxt;

  // rx_ready is held low for the cycle in which reset is released.
  logic              rdy_en_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       shreg_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       drain_q;

  logic              mem_w_en_q;
  logic [ADDR_W-1:0] mem_ptr_q;
  logic [31:0]       mem_data_q;
  logic              pkt_avail_q;
  logic [ADDR_W-1:0] pkt_end_q;
  logic              err_len_q;

  logic              rx_ready_c;
  logic              accept;
  logic              word_done;
  logic [31:0]       word;
  logic              hdr_ok;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_word;

  assign accept    = bus.rx_valid && rx_ready_c;
  assign word_done = accept && (byte_idx_q == 2'd3);
  // The three earlier bytes sit in the shift register; the 4th byte is live on rx_byte.
  assign word      = {shreg_q, bus.rx_byte};
  assign hdr_ok    = (word != 32'd0) && (word <= BUF_WORDS);
  assign cnt_inc   = cnt_q + 1'b1;
  assign last_word = (cnt_inc == len_q);

  // State register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and rx_ready decode
  always_comb begin
    state_nxt  = state_q;
    rx_ready_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        rx_ready_c = rdy_en_q;
        if (word_done) begin
          if (hdr_ok) begin
            state_nxt = S_COLLECT;
          end else if (word == 32'd0) begin
            // Zero length: nothing to drain, the next word is a new header.
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_COLLECT: begin
        rx_ready_c = rdy_en_q;
        if (word_done) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.mem_done) begin
          state_nxt = last_word ? S_AVAIL : S_COLLECT;
        end
      end
      S_AVAIL: begin
        if (bus.dpr_done) begin
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Wait for the router to drop dpr_done so a stale level cannot release the next packet.
        if (!bus.dpr_done) begin
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        rx_ready_c = rdy_en_q;
        if (word_done && (drain_q == 32'd1)) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rdy_en_q    <= 1'b0;
      byte_idx_q  <= 2'd0;
      shreg_q     <= 24'd0;
      len_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= 32'd0;
      mem_w_en_q  <= 1'b0;
      mem_ptr_q   <= BUF_BASE;
      mem_data_q  <= 32'd0;
      pkt_avail_q <= 1'b0;
      pkt_end_q   <= BUF_BASE;
      err_len_q   <= 1'b0;
    end else begin
      rdy_en_q  <= 1'b1;
      err_len_q <= 1'b0;

      if (accept) begin
        byte_idx_q <= byte_idx_q + 2'd1;
        shreg_q    <= {shreg_q[15:0], bus.rx_byte};
      end

      case (state_q)
        S_IDLE: begin
          if (word_done) begin
            if (hdr_ok) begin
              len_q <= word[CNT_W-1:0];
              cnt_q <= '0;
            end else begin
              err_len_q <= 1'b1;
              drain_q   <= word;
            end
          end
        end
        S_COLLECT: begin
          if (word_done) begin
            mem_w_en_q <= 1'b1;
            mem_ptr_q  <= BUF_BASE + ADDR_W'(cnt_q);
            mem_data_q <= word;
          end
        end
        S_WRITE: begin
          if (bus.mem_done) begin
            mem_w_en_q <= 1'b0;
            cnt_q      <= cnt_inc;
            if (last_word) begin
              pkt_avail_q <= 1'b1;
              pkt_end_q   <= BUF_BASE + ADDR_W'(len_q);
            end
          end
        end
        S_AVAIL: begin
          if (bus.dpr_done) begin
            pkt_avail_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (word_done) begin
            drain_q <= drain_q - 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready_c;
  assign bus.mem_w_en  = mem_w_en_q;
  assign bus.mem_ptr   = mem_ptr_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.pkt_avail = pkt_avail_q;
  assign bus.pkt_begin = BUF_BASE;
  assign bus.pkt_end   = pkt_end_q;
  assign bus.err_len   = err_len_q;

endmodule

// File: tb/tb_spi_pkt_ingest.sv
// Directed bench for spi_pkt_ingest: byte source and router driven from one initial block,
// a memory responder with programmable mem_done delay, and monitors for err_len / mem_w_en activity.
module tb_spi_pkt_ingest;

  localparam int unsigned ADDR_W = 23;
  localparam logic [22:0] BASE   = 23'h300000;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;

  spi_pkt_ingest_if #(.ADDR_W(ADDR_W)) bus ();

  spi_pkt_ingest #(
    .ADDR_W   (ADDR_W),
    .BUF_BASE (BASE),
    .BUF_WORDS(1024)
  ) dut (
    .clk  (clk),
    .rst_l(rst_l),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory responder state
  int          mem_delay = 1;
  int          age = 0;
  int          wr_n = 0;
  logic [22:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [22:0] hold_ptr;
  logic [31:0] hold_data;
  int          stab_err = 0;
  int          rdy_viol = 0;
  int          wen_cyc = 0;
  int          err_cnt = 0;

  // mem_done goes high mem_delay cycles after mem_w_en first appears, for one cycle.
  always @(negedge clk) begin
    if (!rst_l || !bus.mem_w_en) begin
      bus.mem_done = 1'b0;
      age = 0;
    end else if (bus.mem_done) begin
      bus.mem_done = 1'b0;
      age = 0;
    end else begin
      age++;
      if (age == 1) begin
        hold_ptr  = bus.mem_ptr;
        hold_data = bus.mem_data;
      end else if ((bus.mem_ptr !== hold_ptr) || (bus.mem_data !== hold_data)) begin
        stab_err++;
      end
      if (bus.rx_ready) rdy_viol++;
      if (age >= mem_delay + 1) begin
        bus.mem_done = 1'b1;
        if (wr_n < 64) begin
          wr_addr[wr_n] = bus.mem_ptr;
          wr_data[wr_n] = bus.mem_data;
        end
        wr_n++;
      end
    end
    if (rst_l && bus.mem_w_en) wen_cyc++;
    if (rst_l && bus.err_len)  err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.rx_ready) begin
        got = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("rx_accept_timeout", 64'(got), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_avail(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.pkt_avail) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, 64'(got), 64'd1);
  endtask

  task automatic release_pkt(input string tag);
    bus.dpr_done = 1'b1;
    @(negedge clk);
    chk({tag, "_avail_drop"}, 64'(bus.pkt_avail), 64'd0);
    bus.dpr_done = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy_back"}, 64'(bus.rx_ready), 64'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"},  64'(bus.rx_ready),  64'd0);
    chk({tag, "_w_en"},      64'(bus.mem_w_en),  64'd0);
    chk({tag, "_ptr"},       64'(bus.mem_ptr),   64'h300000);
    chk({tag, "_data"},      64'(bus.mem_data),  64'd0);
    chk({tag, "_avail"},     64'(bus.pkt_avail), 64'd0);
    chk({tag, "_begin"},     64'(bus.pkt_begin), 64'h300000);
    chk({tag, "_end"},       64'(bus.pkt_end),   64'h300000);
    chk({tag, "_err_len"},   64'(bus.err_len),   64'd0);
  endtask

  int base;
  int eb;
  int wb;
  int sv;
  int rv;

  initial begin
    bus.rx_byte  = 8'd0;
    bus.rx_valid = 1'b0;
    bus.dpr_done = 1'b0;
    rst_l        = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_l = 1'b1;
    @(negedge clk);
    chk("rst_rdy_after", 64'(bus.rx_ready), 64'd1);

    // Two-word packet, mem_done one cycle after each w_en
    mem_delay = 1;
    base = wr_n;
    send_word(32'h0000_0002);
    send_word(32'hDEAD_BEEF);
    chk("t1_w0_lat", 64'(bus.mem_w_en), 64'd1);
    chk("t1_w0_ptr", 64'(bus.mem_ptr),  64'h300000);
    chk("t1_w0_dat", 64'(bus.mem_data), 64'hDEADBEEF);
    send_word(32'h0123_4567);
    bus.rx_valid = 1'b0;
    chk("t1_w1_lat", 64'(bus.mem_w_en), 64'd1);
    @(negedge clk);
    chk("t1_avail_early", 64'(bus.pkt_avail), 64'd0);
    @(negedge clk);
    chk("t1_avail_lat", 64'(bus.pkt_avail), 64'd1);
    chk("t1_nwr",   64'(wr_n - base),     64'd2);
    chk("t1_a0",    64'(wr_addr[base]),   64'h300000);
    chk("t1_d0",    64'(wr_data[base]),   64'hDEADBEEF);
    chk("t1_a1",    64'(wr_addr[base+1]), 64'h300001);
    chk("t1_d1",    64'(wr_data[base+1]), 64'h01234567);
    chk("t1_begin", 64'(bus.pkt_begin),   64'h300000);
    chk("t1_end",   64'(bus.pkt_end),     64'h300002);
    chk("t1_rdy",   64'(bus.rx_ready),    64'd0);
    release_pkt("t1");

    // Same packet, slow memory, rx_valid held high throughout
    mem_delay = 5;
    base = wr_n;
    sv = stab_err;
    rv = rdy_viol;
    send_word(32'h0000_0002);
    send_word(32'hDEAD_BEEF);
    send_word(32'h0123_4567);
    bus.rx_valid = 1'b0;
    wait_avail("t2_avail");
    chk("t2_nwr",    64'(wr_n - base),       64'd2);
    chk("t2_a0",     64'(wr_addr[base]),     64'h300000);
    chk("t2_d0",     64'(wr_data[base]),     64'hDEADBEEF);
    chk("t2_a1",     64'(wr_addr[base+1]),   64'h300001);
    chk("t2_d1",     64'(wr_data[base+1]),   64'h01234567);
    chk("t2_stable", 64'(stab_err - sv),     64'd0);
    chk("t2_rdy_lo", 64'(rdy_viol - rv),     64'd0);
    chk("t2_end",    64'(bus.pkt_end),       64'h300002);

    // dpr_done held for three cycles
    bus.dpr_done = 1'b1;
    @(negedge clk);
    chk("t5_avail_drop", 64'(bus.pkt_avail), 64'd0);
    chk("t5_rdy_c1",     64'(bus.rx_ready),  64'd0);
    @(negedge clk);
    chk("t5_rdy_c2",     64'(bus.rx_ready),  64'd0);
    @(negedge clk);
    chk("t5_rdy_c3",     64'(bus.rx_ready),  64'd0);
    bus.dpr_done = 1'b0;
    @(negedge clk);
    chk("t5_rdy_back",   64'(bus.rx_ready),  64'd1);

    // Oversized header 1025 -> drain 4100 bytes, then a 1-word packet
    mem_delay = 1;
    eb = err_cnt;
    wb = wen_cyc;
    base = wr_n;
    send_word(32'h0000_0401);
    chk("t3_err_pulse", 64'(bus.err_len), 64'd1);
    for (int i = 0; i < 4100; i++) send_byte(8'(i));
    chk("t3_err_once",  64'(err_cnt - eb), 64'd1);
    chk("t3_no_wen",    64'(wen_cyc - wb), 64'd0);
    send_word(32'h0000_0001);
    send_word(32'hCAFE_F00D);
    bus.rx_valid = 1'b0;
    wait_avail("t3_avail");
    chk("t3_nwr", 64'(wr_n - base),     64'd1);
    chk("t3_a0",  64'(wr_addr[base]),   64'h300000);
    chk("t3_d0",  64'(wr_data[base]),   64'hCAFEF00D);
    chk("t3_end", 64'(bus.pkt_end),     64'h300001);
    release_pkt("t3");

    // Zero-length header, next word is a fresh header
    eb = err_cnt;
    base = wr_n;
    send_word(32'h0000_0000);
    chk("t4_err_pulse", 64'(bus.err_len), 64'd1);
    send_word(32'h0000_0001);
    send_word(32'h0BAD_C0DE);
    bus.rx_valid = 1'b0;
    wait_avail("t4_avail");
    chk("t4_err_once", 64'(err_cnt - eb),   64'd1);
    chk("t4_nwr",      64'(wr_n - base),    64'd1);
    chk("t4_d0",       64'(wr_data[base]),  64'h0BADC0DE);
    chk("t4_end",      64'(bus.pkt_end),    64'h300001);
    release_pkt("t4");

    // Reset during the third payload write of a 4-word packet
    mem_delay = 20;
    send_word(32'h0000_0004);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    bus.rx_valid = 1'b0;
    chk("t6_w2_en",  64'(bus.mem_w_en), 64'd1);
    chk("t6_w2_ptr", 64'(bus.mem_ptr),  64'h300002);
    chk("t6_w2_dat", 64'(bus.mem_data), 64'h33333333);
    #2 rst_l = 1'b0;
    #1 chk_reset_vals("t6_rst");
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    mem_delay = 1;
    @(negedge clk);
    chk("t6_rdy_after", 64'(bus.rx_ready), 64'd1);
    base = wr_n;
    send_word(32'h0000_0001);
    send_word(32'h5A5A_A5A5);
    bus.rx_valid = 1'b0;
    wait_avail("t6_avail");
    chk("t6_nwr", 64'(wr_n - base),    64'd1);
    chk("t6_a0",  64'(wr_addr[base]),  64'h300000);
    chk("t6_d0",  64'(wr_data[base]),  64'h5A5AA5A5);
    chk("t6_end", 64'(bus.pkt_end),    64'h300001);
    release_pkt("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
